// File: rtl/dmem_resp.sv
// Byte-masked data memory responder: one outstanding request, fixed LATENCY response.
// Optional DMEM_RESP_ALIGN_CHECK_EN flags misaligned addresses / illegal masks via o_rsp_err.
module dmem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wen,
  input  logic        i_req_ren,
  input  logic [31:0] i_req_addr,
  input  logic [3:0]  i_req_mask,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        ready_q;
  logic        rsp_valid_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic          wen_q;
  logic          ren_q;
  logic [AW-1:0] idx_q;
  logic [3:0]    mask_q;
  logic [31:0]   wdata_q;
  logic          bad_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          handshake;
  logic          enter_resp;
  logic          req_bad;
  logic          acc_wen;
  logic          acc_ren;
  logic [AW-1:0] acc_idx;
  logic [3:0]    acc_mask;
  logic [31:0]   acc_wdata;
  logic          acc_bad;
  logic [31:0]   lane_mask;
  logic [31:0]   rd_word;
  logic          mem_we;

`ifdef DMEM_RESP_ALIGN_CHECK_EN
  function automatic logic mask_legal(input logic [3:0] m);
    case (m)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: mask_legal = 1'b1;
      default:                   mask_legal = 1'b0;
    endcase
  endfunction

  logic unused_addr;
  assign unused_addr = ^i_req_addr[31:AW+2];
  assign req_bad = (i_req_addr[1:0] != 2'b00) |
                   ((i_req_wen | i_req_ren) & ~mask_legal(i_req_mask));
`else
  logic unused_addr;
  assign unused_addr = ^{i_req_addr[31:AW+2], i_req_addr[1:0]};
  assign req_bad = 1'b0;
`endif

  assign handshake = i_req_valid & ready_q;

  // With LATENCY==1 the commit edge is the accept edge, so the live request is used directly.
  assign enter_resp = ((state_q == ST_IDLE) && handshake && (LATENCY == 1)) ||
                      ((state_q == ST_BUSY) && (cnt_q == 4'd1));

  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_wen   = i_req_wen;
      acc_ren   = i_req_ren;
      acc_idx   = i_req_addr[AW+1:2];
      acc_mask  = i_req_mask;
      acc_wdata = i_req_wdata;
      acc_bad   = req_bad;
    end else begin
      acc_wen   = wen_q;
      acc_ren   = ren_q;
      acc_idx   = idx_q;
      acc_mask  = mask_q;
      acc_wdata = wdata_q;
      acc_bad   = bad_q;
    end
  end

  assign lane_mask = {{8{acc_mask[3]}}, {8{acc_mask[2]}}, {8{acc_mask[1]}}, {8{acc_mask[0]}}};
  assign rd_word   = mem_q[acc_idx];
  assign mem_we    = enter_resp & ~i_rst & acc_wen & ~acc_bad;

  // Array write shares the RESP-entry edge with the read sample; the read sees the old word.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int n = 0; n < 4; n++) begin
        if (acc_mask[n]) begin
          mem_q[acc_idx][8*n +: 8] <= acc_wdata[8*n +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      idx_q       <= '0;
      mask_q      <= 4'd0;
      wdata_q     <= 32'd0;
      bad_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        rdata_q     <= acc_ren ? (rd_word & lane_mask) : 32'd0;
        err_q       <= acc_bad;
      end

      case (state_q)
        ST_IDLE: begin
          if (handshake) begin
            wen_q   <= i_req_wen;
            ren_q   <= i_req_ren;
            idx_q   <= i_req_addr[AW+1:2];
            mask_q  <= i_req_mask;
            wdata_q <= i_req_wdata;
            bad_q   <= req_bad;
            cnt_q   <= 4'(LATENCY - 1);
            ready_q <= 1'b0;
            state_q <= (LATENCY > 1) ? ST_BUSY : ST_RESP;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_BUSY: begin
          ready_q <= 1'b0;
          if (cnt_q == 4'd1) begin
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready = ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: two instances (LATENCY=2 and LATENCY=3) share request wires.
// Alignment-check expectations follow DMEM_RESP_ALIGN_CHECK_EN.
module tb_dmem_resp;

`ifdef DMEM_RESP_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v2, v3;
  logic        wen, ren;
  logic [31:0] addr;
  logic [3:0]  mask;
  logic [31:0] wdata;

  logic        rdy2, rv2, err2;
  logic [31:0] rd2;
  logic        rdy3, rv3, err3;
  logic [31:0] rd3;

  int n_checks = 0;
  int n_errors = 0;

  dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(v2), .o_req_ready(rdy2),
    .i_req_wen(wen), .i_req_ren(ren), .i_req_addr(addr), .i_req_mask(mask),
    .i_req_wdata(wdata), .o_rsp_valid(rv2), .o_rsp_rdata(rd2), .o_rsp_err(err2)
  );

  dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(v3), .o_req_ready(rdy3),
    .i_req_wen(wen), .i_req_ren(ren), .i_req_addr(addr), .i_req_mask(mask),
    .i_req_wdata(wdata), .o_rsp_valid(rv3), .o_rsp_rdata(rd3), .o_rsp_err(err3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sample(input bit sel, output logic rdy, output logic rv,
                        output logic [31:0] rd, output logic er);
    if (sel) begin rdy = rdy3; rv = rv3; rd = rd3; er = err3; end
    else     begin rdy = rdy2; rv = rv2; rd = rd2; er = err2; end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input bit sel, input logic w, input logic r, input logic [31:0] a,
                      input logic [3:0] m, input logic [31:0] d,
                      output logic [31:0] rd_o, output logic er_o);
    int lat;
    int k;
    logic rdy, rv, er;
    logic [31:0] rd;
    lat  = sel ? 3 : 2;
    rd_o = 32'hx;
    er_o = 1'bx;
    wen = w; ren = r; addr = a; mask = m; wdata = d;
    k = 0;
    sample(sel, rdy, rv, rd, er);
    while (!rdy && k < 20) begin
      cyc();
      sample(sel, rdy, rv, rd, er);
      k++;
    end
    if (!rdy) check("ready_timeout", 32'(rdy), 32'd1);
    if (sel) v3 = 1'b1; else v2 = 1'b1;
    cyc();
    v2 = 1'b0; v3 = 1'b0;
    wen = 1'b1; ren = 1'b1; addr = 32'hFFFF_FFFC; mask = 4'hF; wdata = 32'hFFFF_FFFF;
    for (int c = 1; c <= lat; c++) begin
      sample(sel, rdy, rv, rd, er);
      check("rsp_valid_timing", 32'(rv), 32'(c == lat));
      check("ready_low_busy", 32'(rdy), 32'd0);
      if (c == lat) begin
        rd_o = rd;
        er_o = er;
      end else begin
        cyc();
      end
    end
    cyc();
    sample(sel, rdy, rv, rd, er);
    check("ready_after_rsp", 32'(rdy), 32'd1);
    check("rsp_valid_drop", 32'(rv), 32'd0);
    check("rdata_hold", rd, rd_o);
    check("err_hold", 32'(er), 32'(er_o));
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    rst = 1'b1; v2 = 1'b0; v3 = 1'b0;
    wen = 1'b0; ren = 1'b0; addr = 32'd0; mask = 4'd0; wdata = 32'd0;
    repeat (3) cyc();
    check("rst_ready", 32'(rdy2), 32'd0);
    check("rst_rsp_valid", 32'(rv2), 32'd0);
    check("rst_rdata", rd2, 32'd0);
    check("rst_err", 32'(err2), 32'd0);
    rst = 1'b0;
    check("ready_deassert_cycle", 32'(rdy2), 32'd0);
    cyc();
    check("ready_after_rst", 32'(rdy2), 32'd1);

    // full write then read back
    xact(0, 1, 0, 32'h10, 4'hF, 32'hDEADBEEF, rd, er);
    check("wr_full_err", 32'(er), 32'd0);
    xact(0, 0, 1, 32'h10, 4'hF, 32'h0, rd, er);
    check("rd_full", rd, 32'hDEADBEEF);

    // single-lane write, masked reads
    xact(0, 1, 0, 32'h20, 4'hF, 32'h00000000, rd, er);
    xact(0, 1, 0, 32'h20, 4'b0100, 32'h00AB0000, rd, er);
    xact(0, 0, 1, 32'h20, 4'hF, 32'h0, rd, er);
    check("rd_lane2", rd, 32'h00AB0000);
    xact(0, 0, 1, 32'h20, 4'b0011, 32'h0, rd, er);
    check("rd_mask0011", rd, 32'h00000000);

    // read-before-write
    xact(0, 1, 0, 32'h30, 4'hF, 32'h11223344, rd, er);
    xact(0, 1, 1, 32'h30, 4'b1100, 32'hAAAA0000, rd, er);
    check("rbw_rdata", rd, 32'h11220000);
    xact(0, 0, 1, 32'h30, 4'hF, 32'h0, rd, er);
    check("rbw_after", rd, 32'hAAAA3344);

    // address wrap at 1024 words
    xact(0, 1, 0, 32'h00001000, 4'hF, 32'h5A5A5A5A, rd, er);
    xact(0, 0, 1, 32'h0, 4'hF, 32'h0, rd, er);
    check("addr_wrap", rd, 32'h5A5A5A5A);

    // no-op access and empty-mask write
    xact(0, 0, 0, 32'h10, 4'hF, 32'h0, rd, er);
    check("noop_rdata", rd, 32'h0);
    xact(0, 1, 0, 32'h10, 4'b0000, 32'hFFFFFFFF, rd, er);
    check("mask0_err", 32'(er), 32'(CHK));
    xact(0, 0, 1, 32'h10, 4'hF, 32'h0, rd, er);
    check("mask0_nowrite", rd, 32'hDEADBEEF);

    // reset one cycle after accepting a write (LATENCY=3)
    xact(1, 1, 0, 32'h40, 4'hF, 32'h12345678, rd, er);
    wen = 1'b1; ren = 1'b0; addr = 32'h40; mask = 4'hF; wdata = 32'hCAFEF00D;
    v3 = 1'b1;
    cyc();
    v3 = 1'b0;
    rst = 1'b1;
    cyc();
    check("midrst_valid", 32'(rv3), 32'd0);
    rst = 1'b0;
    check("midrst_ready", 32'(rdy3), 32'd0);
    for (int c = 0; c < 5; c++) begin
      cyc();
      check("midrst_no_rsp", 32'(rv3), 32'd0);
    end
    xact(1, 0, 1, 32'h40, 4'hF, 32'h0, rd, er);
    check("midrst_nowrite", rd, 32'h12345678);

    // alignment / mask legality
    xact(0, 1, 0, 32'h50, 4'hF, 32'h01020304, rd, er);
    xact(0, 1, 0, 32'h52, 4'b0011, 32'h0000BEEF, rd, er);
    check("misalign_err", 32'(er), 32'(CHK));
    xact(0, 0, 1, 32'h50, 4'hF, 32'h0, rd, er);
    check("misalign_word", rd, CHK ? 32'h01020304 : 32'h0102BEEF);
    xact(0, 1, 0, 32'h50, 4'b0110, 32'h00ABCD00, rd, er);
    check("badmask_err", 32'(er), 32'(CHK));
    xact(0, 0, 1, 32'h50, 4'hF, 32'h0, rd, er);
    check("badmask_word", rd, CHK ? 32'h01020304 : 32'h01ABCDEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
